// File: rtl/Config.sv
// Shared configuration for the output collector: array geometry, FIFO depth,
// row counter sizing and the packed row type.
// Optional feature macro: OF_RELU_EN (adds the signed ReLU helper used at push).
package Config;

    localparam int sys_cols      = 4;
    localparam int P_BITWIDTH    = 16;
    localparam int A_rows        = 3;
    localparam int counter_width = 8;
    localparam int OF_DEPTH      = 4;

    // One result row; column c occupies bits [c*P_BITWIDTH +: P_BITWIDTH].
    typedef logic [sys_cols-1:0][P_BITWIDTH-1:0] row_t;

`ifdef OF_RELU_EN
    // Clamp every signed element of a row at zero.
    function automatic row_t relu_row(row_t r);
        row_t o;
        for (int c = 0; c < sys_cols; c++) begin
            o[c] = r[c][P_BITWIDTH-1] ? '0 : r[c];
        end
        return o;
    endfunction
`endif

endpackage

// File: rtl/of_deskew.sv
// Deskew stage for the skewed systolic outputs. Column c arrives c cycles
// after its row's of_valid, so it is delayed by sys_cols-1-c cycles; the
// last column passes straight through. of_valid is delayed sys_cols-1 cycles
// to become push, aligned with the completed row.
module of_deskew
    import Config::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic of_valid,
    input  row_t of_data,
    output logic push,
    output row_t row
);

    logic [sys_cols-2:0] vld_q;

    // Valid delay line; clr flushes it so in-flight rows are never pushed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q <= '0;
        end else if (clr) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= of_valid;
            for (int i = 1; i < sys_cols - 1; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign push = vld_q[sys_cols-2];

    for (genvar c = 0; c < sys_cols; c++) begin : g_col
        localparam int D = sys_cols - 1 - c;
        if (D == 0) begin : g_pass
            assign row[c] = of_data[c];
        end else begin : g_dly
            logic [P_BITWIDTH-1:0] sr [D];

            // Per-column data delay; data registers carry no reset.
            always_ff @(posedge clk) begin
                sr[0] <= of_data[c];
                for (int i = 1; i < D; i++) begin
                    sr[i] <= sr[i-1];
                end
            end

            assign row[c] = sr[D-1];
        end
    end

endmodule

// File: rtl/output_collector.sv
// Output collector: deskews systolic result rows, buffers them in an
// OF_DEPTH-row FIFO, counts accepted rows up to A_rows and flags drops.
// Optional feature macro: OF_RELU_EN (signed ReLU applied to each element
// as the row is written into the FIFO).
// rows_done is registered: it is high in the cycle after the edge that
// stores the A_rows-th row, alongside the updated o_count.
module output_collector
    import Config::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       of_valid,
    input  row_t                       of_data,
    output logic                       o_valid,
    input  logic                       o_ready,
    output row_t                       o_data,
    output logic [$clog2(OF_DEPTH):0]  o_count,
    output logic                       rows_done,
    output logic                       overflow
);

    localparam int AW = $clog2(OF_DEPTH);

    logic                     push;
    row_t                     dsk_row;
    row_t                     push_row;
    row_t                     mem [OF_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [AW:0]              count;
    logic [counter_width-1:0] row_cnt;
    logic                     full;
    logic                     do_push;
    logic                     do_pop;

    of_deskew u_deskew (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .of_valid (of_valid),
        .of_data  (of_data),
        .push     (push),
        .row      (dsk_row)
    );

`ifdef OF_RELU_EN
    assign push_row = relu_row(dsk_row);
`else
    assign push_row = dsk_row;
`endif

    assign full    = (count == (AW+1)'(OF_DEPTH));
    assign o_valid = (count != '0);
    assign do_pop  = o_valid && o_ready && !clr;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !clr && (!full || do_pop);

    assign o_count = count;
    assign o_data  = o_valid ? mem[rd_ptr] : '0;

    // FIFO storage; written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_row;
        end
    end

    // Pointers, occupancy, row counter and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            row_cnt   <= '0;
            rows_done <= 1'b0;
            overflow  <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            row_cnt   <= '0;
            rows_done <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            rows_done <= do_push && (row_cnt == counter_width'(A_rows - 1));
            if (do_push && (row_cnt < counter_width'(A_rows))) begin
                row_cnt <= row_cnt + 1'b1;
            end
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_collector.sv
// Self-checking bench for output_collector: directed scenarios plus a random
// phase, compared cycle by cycle against a queue-based reference model.
module tb_output_collector;
    import Config::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      clr;
    logic                      of_valid;
    row_t                      of_data;
    logic                      o_valid;
    logic                      o_ready;
    row_t                      o_data;
    logic [$clog2(OF_DEPTH):0] o_count;
    logic                      rows_done;
    logic                      overflow;

    output_collector dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .of_valid  (of_valid),
        .of_data   (of_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_count   (o_count),
        .rows_done (rows_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        int   due;
        row_t row;
    } pend_t;

    pend_t pend[$];
    row_t  fifo[$];
    int    m_cnt;
    bit    m_ovf;
    bit    m_done;
    row_t  hist_row [sys_cols];
    bit    hist_v   [sys_cols];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic row_t xform(input row_t r);
        row_t o;
        o = r;
`ifdef OF_RELU_EN
        for (int c = 0; c < sys_cols; c++) begin
            if ($signed(r[c]) < 0) o[c] = '0;
        end
`endif
        return o;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int c = 0; c < sys_cols; c++) r[c] = 16'($urandom);
        return r;
    endfunction

    function automatic row_t mk_row(input logic [15:0] a, b, c, d);
        row_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    task automatic model_clear();
        pend.delete();
        fifo.delete();
        m_cnt  = 0;
        m_ovf  = 0;
        m_done = 0;
        for (int j = 0; j < sys_cols; j++) hist_v[j] = 0;
    endtask

    task automatic check_outputs();
        chk("o_valid",   64'(o_valid),   64'(fifo.size() != 0));
        chk("o_count",   64'(o_count),   64'(fifo.size()));
        chk("overflow",  64'(overflow),  64'(m_ovf));
        chk("rows_done", 64'(rows_done), 64'(m_done));
        if (fifo.size() != 0) chk("o_data", o_data, fifo[0]);
    endtask

    // One clock cycle: check state left by the previous edge, drive this
    // cycle's inputs, then advance the reference model across the edge.
    task automatic step(input bit v, input row_t r, input bit c, input bit rdy);
        bit    pop;
        bit    psh;
        row_t  pr;
        pend_t p;
        @(negedge clk);
        check_outputs();
        for (int j = sys_cols - 1; j > 0; j--) begin
            hist_row[j] = hist_row[j-1];
            hist_v[j]   = hist_v[j-1];
        end
        hist_row[0] = r;
        hist_v[0]   = v;
        for (int col = 0; col < sys_cols; col++) begin
            of_data[col] = hist_v[col] ? hist_row[col][col] : 16'($urandom);
        end
        of_valid = v;
        clr      = c;
        o_ready  = rdy;

        if (v) begin
            p.due = cyc + sys_cols - 1;
            p.row = r;
            pend.push_back(p);
        end
        if (c) begin
            pend.delete();
            fifo.delete();
            m_cnt  = 0;
            m_ovf  = 0;
            m_done = 0;
        end else begin
            pop    = (fifo.size() != 0) && rdy;
            psh    = 0;
            m_done = 0;
            if (pend.size() != 0 && pend[0].due == cyc) begin
                psh = 1;
                pr  = pend[0].row;
                void'(pend.pop_front());
            end
            if (pop) void'(fifo.pop_front());
            if (psh) begin
                if (fifo.size() < OF_DEPTH) begin
                    fifo.push_back(xform(pr));
                    if (m_cnt < A_rows) begin
                        m_cnt++;
                        m_done = (m_cnt == A_rows);
                    end
                end else begin
                    m_ovf = 1;
                end
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, rand_row(), 0, rdy);
    endtask

    // Single row with column c = 10+c, checking exact latency to o_valid.
    task automatic single_row_timing(input string tag);
        row_t r;
        r = mk_row(16'd10, 16'd11, 16'd12, 16'd13);
        step(1, r, 0, 0);
        idle(2, 0);
        #1 chk({tag, "_early"}, 64'(o_valid), 64'd0);
        idle(1, 0);
        #1 chk({tag, "_valid"}, 64'(o_valid), 64'd1);
        chk({tag, "_data"}, o_data, 64'h000d_000c_000b_000a);
        idle(2, 1);
    endtask

    initial begin
        rst      = 1'b0;
        clr      = 1'b0;
        of_valid = 1'b0;
        o_ready  = 1'b0;
        of_data  = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_o_valid", 64'(o_valid), 64'd0);
        chk("reset_o_count", 64'(o_count), 64'd0);
        chk("reset_o_data",  o_data,       64'd0);
        @(negedge clk);
        rst = 1'b1;

        single_row_timing("single");

        // Five back-to-back rows into a 4-deep FIFO with no consumer.
        step(0, rand_row(), 1, 0);
        for (int i = 0; i < 5; i++) step(1, rand_row(), 0, 0);
        idle(4, 0);
        #1 chk("burst_count", 64'(o_count), 64'd4);
        chk("burst_overflow", 64'(overflow), 64'd1);

        // Full FIFO with a pop coinciding with the push: no drop.
        step(0, rand_row(), 1, 0);
        for (int i = 0; i < 5; i++) step(1, rand_row(), 0, 0);
        idle(2, 0);
        idle(1, 1);
        #1 chk("fullpop_count", 64'(o_count), 64'd4);
        chk("fullpop_overflow", 64'(overflow), 64'd0);
        idle(6, 1);

        // clr two cycles after of_valid kills the in-flight row.
        step(1, rand_row(), 0, 0);
        idle(1, 0);
        step(0, rand_row(), 1, 0);
        idle(4, 0);
        #1 chk("clr_count", 64'(o_count), 64'd0);
        chk("clr_valid", 64'(o_valid), 64'd0);
        chk("clr_overflow", 64'(overflow), 64'd0);

        // Negative and positive element values.
        step(1, mk_row(16'hFFF6, 16'h0005, 16'hFFF6, 16'h0005), 0, 0);
        idle(3, 0);
`ifdef OF_RELU_EN
        #1 chk("relu_data", o_data, 64'h0005_0000_0005_0000);
`else
        #1 chk("relu_data", o_data, 64'h0005_FFF6_0005_FFF6);
`endif
        idle(2, 1);

        // Asynchronous reset in the middle of a burst.
        step(1, rand_row(), 0, 0);
        step(1, rand_row(), 0, 0);
        step(1, rand_row(), 0, 0);
        step(1, rand_row(), 0, 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_o_valid",   64'(o_valid),   64'd0);
        chk("arst_o_count",   64'(o_count),   64'd0);
        chk("arst_overflow",  64'(overflow),  64'd0);
        chk("arst_rows_done", 64'(rows_done), 64'd0);
        chk("arst_o_data",    o_data,         64'd0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        of_valid = 1'b0;
        clr      = 1'b0;
        o_ready  = 1'b0;
        rst      = 1'b1;
        single_row_timing("post_rst");

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 2) != 0), rand_row(),
                 ($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1));
        end
        idle(8, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/output_collector.md
OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 clr  input  1  synchronous clear of collector state; takes priority over all other inputs except rst.
REQ-004 of_valid  input  1  high in the cycle column 0 of of_data carries a valid result row.
REQ-005 of_data  input  sys_cols x P_BITWIDTH  skewed systolic outputs; column c of a row is valid c cycles after that row's of_valid.
REQ-006 o_valid  output  1  head row available.
REQ-007 o_ready  input  1  consumer accepts head row when o_valid and o_ready are both high.
REQ-008 o_data  output  sys_cols x P_BITWIDTH  deskewed head row, all columns aligned.
REQ-009 o_count  output  $clog2(OF_DEPTH)+1  rows currently stored.
REQ-010 rows_done  output  1  one-cycle pulse when the A_rows-th row since the last clr/reset is pushed.
REQ-011 overflow  output  1  sticky; set when a row is dropped.

Function
REQ-012 Deskew: column c is delayed by sys_cols-1-c cycles; of_valid is delayed sys_cols-1 cycles to form push.
REQ-013 A row with of_valid at cycle t is written into storage at edge t+sys_cols-1; o_valid rises the next cycle when storage was empty.
REQ-014 Back-to-back of_valid on consecutive cycles yields consecutive pushes with no gap; up to sys_cols rows are in flight in the deskew pipeline.
REQ-015 Storage is a FIFO of OF_DEPTH rows (power of two); pointers wrap modulo OF_DEPTH.
REQ-016 A pop occurs when o_valid and o_ready are high; o_data shows the oldest row; o_data is don't-care when o_valid is low.
REQ-017 Push while full with no simultaneous pop: row dropped, overflow set, o_count unchanged.
REQ-018 Push and pop in the same cycle while full: both occur, no overflow, o_count unchanged.
REQ-019 Push and pop in the same cycle while not empty: o_count unchanged. Pop while empty is ignored.
REQ-020 The row counter (counter_width bits) increments per accepted push; rows_done pulses on the push that makes it A_rows-1 → A_rows; the counter then holds at A_rows until clr.
REQ-021 Dropped rows do not increment the row counter.
REQ-022 clr empties the FIFO, flushes the deskew valid pipeline (in-flight rows are lost), and zeroes the row counter and overflow.

Reset
REQ-023 rst low: o_valid=0, o_count=0, rows_done=0, overflow=0, pointers=0, and the deskew valid pipeline is cleared.
REQ-024 Data registers need not be reset; o_data reads 0 after reset.
REQ-025 Reset mid-operation discards all stored and in-flight rows; the first row after release behaves as in REQ-013.

Configuration
REQ-026 With OF_RELU_EN defined: each P_BITWIDTH element is treated as signed, and negative values are replaced by 0 at push.
REQ-027 Without OF_RELU_EN: values pass through unmodified; no ReLU logic is present.

Structure
REQ-028 sys_cols, P_BITWIDTH, A_rows, counter_width and the new OF_DEPTH constant live in package Config.
REQ-029 The row type (sys_cols x P_BITWIDTH packed) is a typedef in Config.
REQ-030 Sub-module of_deskew holds the per-column delay lines and the valid delay; the FIFO and counters stay in output_collector.

Verification (sys_cols=4, P_BITWIDTH=16, OF_DEPTH=4, A_rows=3)
REQ-031 Single row: of_valid at cycle 0; column c = 10+c at cycle c → o_valid at cycle 4 with o_data={13,12,11,10}.
REQ-032 Burst: 5 back-to-back rows, o_ready=0 → 4 stored, o_count=4, overflow=1 after the 5th push; rows_done pulses on the 3rd push.
REQ-033 Full with o_ready=1 continuously during a push → no overflow, o_count stays 4, rows pop in order.
REQ-034 clr asserted 2 cycles after of_valid → that row never appears; o_count=0; overflow=0.
REQ-035 OF_RELU_EN: input column value 16'hFFF6 (-10) → output 0; 16'h0005 → 5. Without the macro, 16'hFFF6 passes through unchanged.
REQ-036 rst pulsed low mid-burst asynchronously → outputs zero immediately; the next single row follows REQ-031 timing.
